// File: rtl/serial_word_receiver.sv
// Framed serial-to-parallel receiver: start/data/parity/stop check into a small word FIFO.
// Word valid one clk after stop sample; dout held until dout_ready, full FIFO drops word and sets overrun.
module serial_word_receiver #(
    parameter int WIDTH      = 4,
    parameter int PARITY_EN  = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          serialin,
    input  logic                          sample_en,
    output logic [WIDTH-1:0]              dout,
    output logic                          dout_perr,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clear_err,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BRK} state_t;

    state_t             state_q, state_d;
    logic [4:0]         bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               overrun_q, overrun_d;
    logic               push_req;

    logic [WIDTH:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic               full, pop, push, drop;

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        perr_d    = perr_q;
        ferr_d    = 1'b0;
        push_req  = 1'b0;
        if (sample_en) begin
            case (state_q)
                IDLE: begin
                    if (!serialin) begin
                        state_d   = DATA;
                        bit_idx_d = 5'd0;
                        perr_d    = 1'b0;
                    end
                end
                DATA: begin
                    shreg_d   = {serialin, shreg_q[WIDTH-1:1]};
                    bit_idx_d = bit_idx_q + 5'd1;
                    if (bit_idx_q == LAST_BIT) state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
                PARITY: begin
                    perr_d  = (^shreg_q) ^ serialin;
                    state_d = STOP;
                end
                STOP: begin
                    if (serialin) begin
                        push_req = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BRK;
                    end
                end
                BRK: begin
                    // Only a returned-high line re-arms start detection.
                    if (serialin) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign full = (count_q == CW'(FIFO_DEPTH));
    assign pop  = dout_valid & dout_ready;
    assign push = push_req & (~full | pop);
    assign drop = push_req & full & ~pop;

    always_comb begin
        overrun_d = overrun_q;
        if (clear_err) overrun_d = 1'b0;
        if (drop)      overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_idx_q <= 5'd0;
            shreg_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {perr_q, shreg_q};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign dout       = mem_q[rd_ptr_q][WIDTH-1:0];
    assign dout_perr  = mem_q[rd_ptr_q][WIDTH];
    assign dout_valid = (count_q != '0);
    assign count      = count_q;
    assign frame_err  = ferr_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);
endmodule
